mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  Parametrised M->W pipeline stage with a byte-addressable data-memory port for the RISC-V core.
//  Supports LB/LH/LW/LBU/LHU and SB/SH/SW: byte write masks, store-data lane replication, load alignment and sign/zero extension.
//  Detects misaligned accesses, supports stall/flush, and registers M-stage control into W.
// PARAMETERS
//  ADDR_WIDTH  5   word-address bits; DEPTH = 2**ADDR_WIDTH words of 32 bits
//  XLEN        32  data/address width (only 32 supported)
// PORTS
//  clk          in   1     single clock, rising-edge
//  rst_n        in   1     asynchronous, active-low reset
//  stallW       in   1     hold all W registers and the memory read port
//  flushW       in   1     invalidate the instruction entering W
//  validM       in   1     M holds a real instruction
//  reg_wrM      in   1     register-file write enable
//  result_srcM  in   2     writeback mux select (passed through)
//  mem_wrM      in   1     store
//  mem_rdM      in   1     load
//  funct3M      in   3     access size/sign (RV32I encoding)
//  ALU_resultM  in   32    byte address / ALU result
//  wr_dataM     in   32    store data (rs2)
//  PCp4M        in   32    PC+4
//  rdM          in   5     destination register
//  validW, reg_wrW out 1   registered valid / write enable
//  result_srcW  out  2     registered
//  ALU_resultW, PCp4W out 32  registered
//  rdW          out  5     registered
//  rd_dataW     out  32    aligned, extended load data
//  misalignW    out  1     misaligned access reached W
//  faultW       out  1     out-of-range access (0 unless MEM_ACCESS_FAULT_EN)
// BEHAVIOUR
//  Reset (rst_n=0, async): all W outputs 0; no memory write. Memory contents are not reset.
//  Word index = ALU_resultM[ADDR_WIDTH+1:2]; byte offset off = ALU_resultM[1:0], registered as offW with funct3W.
//  Misaligned: halfword with off[0]=1; word with off!=0. Misaligned or faulting accesses never write; on a load, reg_wrW is forced to 0.
//  Write enable = validM & mem_wrM & ~stallW & ~flushW & ~misalign & ~fault.
//  Store mask: SB 4'b0001<<off; SH 4'b0011<<off; SW 4'b1111.
//    Data replication: SB {4{b}}; SH {2{h}}.
//  Memory: one-cycle read latency. Address is sampled at the rising edge ending M; dout is valid in W.
//    The read port is enabled only when ~stallW, so dout holds while stalled.
//  Load path (combinational in W): select lane by offW; LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//    Non-load or misaligned in W: rd_dataW = 0.
//  Stall: all W registers hold. Flush: at the next edge validW, reg_wrW, misalignW and faultW become 0.
//    Flush has priority over stall.
//  Read-after-write to the same word in back-to-back cycles returns the new data (write precedes read in the macro).
//  Reset mid-store: the write is aborted; the memory word content is then undefined.
// CONFIGURATION
//  MEM_ACCESS_FAULT_EN defined:
//    ALU_resultM[31:ADDR_WIDTH+2] != 0 on a load/store sets fault: write suppressed, load data 0, reg_wrW 0, faultW=1 in W.
//  Undefined:
//    Upper address bits are ignored (address wraps modulo DEPTH*4 bytes); faultW tied 0.
// STRUCTURE
//  Package mem_lsu_pkg: funct3 localparams (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5) and an lsu_size_e enum.
//    Also holds functions wmask_gen() and load_align().
//  Sub-module dmem_bank: wraps sram_32_32_sky130A (or a behavioural array under synthesis-off).
//    Presents csb/web/wmask with one-cycle read latency and dout hold when disabled.
// TESTING
//  SW 0xDEADBEEF @0x10, then LW @0x10 -> rd_dataW=0xDEADBEEF one cycle after the load leaves M.
//  SB 0x80 @0x13, then LB @0x13 and LBU @0x13.
//    -> word 0x10 = 0x80ADBEEF; LB=0xFFFFFF80; LBU=0x00000080.
//  SH 0x1234 @0x12, then LHU @0x12 -> 0x00001234; LH @0x11 -> misalignW=1, reg_wrW=0, memory unchanged.
//  Load @0x08 with stallW held 3 cycles, then flushW on the next instruction.
//    -> rd_dataW stable for 3 cycles; the flushed instruction has validW=0.
//  MEM_ACCESS_FAULT_EN: SW @0x100 with ADDR_WIDTH=5 -> faultW=1, no write; without the macro, word 0 is written.
//  Assert rst_n low during a load -> all outputs 0 asynchronously; after release, the first load returns correct data.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared load/store unit definitions: RV32I funct3 codes, access size enum,
// store byte-mask generation, store-lane replication and load alignment helpers.
package mem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    function automatic lsu_size_e size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    return SZ_B;
            2'd1:    return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] wmask_gen(input lsu_size_e size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across all lanes so the byte mask alone picks the target lane.
    function automatic logic [31:0] store_rep(input lsu_size_e size, input logic [31:0] data);
        case (size)
            SZ_B:    return {4{data[7:0]}};
            SZ_H:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] funct3);
        logic [31:0] lane;
        lane = word >> {off, 3'b000};
        case (funct3)
            F3_B:    return {{24{lane[7]}}, lane[7:0]};
            F3_H:    return {{16{lane[15]}}, lane[15:0]};
            F3_BU:   return {24'd0, lane[7:0]};
            F3_HU:   return {16'd0, lane[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-lane data memory: active-low chip select / write enable, per-lane write mask,
// one-cycle registered read, output holds when deselected or writing.
module dmem_bank #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  csb,
    input  logic                  web,
    input  logic [3:0]            wmask,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (!csb && !web && wmask[gi]) begin
                    mem_lane[addr] <= din[gi*8 +: 8];
                end else if (!csb && web) begin
                    q_reg <= mem_lane[addr];
                end
            end

            assign dout[gi*8 +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/mem_stage_lsu.sv
// M->W pipeline stage with byte-addressable data memory port for RV32I loads/stores.
// Define MEM_ACCESS_FAULT_EN to flag accesses beyond the memory range as faults.
module mem_stage_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stallW,
    input  logic            flushW,
    input  logic            validM,
    input  logic            reg_wrM,
    input  logic [1:0]      result_srcM,
    input  logic            mem_wrM,
    input  logic            mem_rdM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] ALU_resultM,
    input  logic [XLEN-1:0] wr_dataM,
    input  logic [XLEN-1:0] PCp4M,
    input  logic [4:0]      rdM,
    output logic            validW,
    output logic            reg_wrW,
    output logic [1:0]      result_srcW,
    output logic [XLEN-1:0] ALU_resultW,
    output logic [XLEN-1:0] PCp4W,
    output logic [4:0]      rdW,
    output logic [XLEN-1:0] rd_dataW,
    output logic            misalignW,
    output logic            faultW
);

    lsu_size_e       size_m;
    logic [1:0]      off_m;
    logic            access_m;
    logic            misalign_m;
    logic            fault_m;
    logic            we_m;
    logic            reg_wr_next;
    logic [XLEN-1:0] dout;

    logic            valid_reg;
    logic            reg_wr_reg;
    logic            misalign_reg;
    logic            fault_reg;
    logic            load_reg;
    logic [1:0]      result_src_reg;
    logic [XLEN-1:0] alu_result_reg;
    logic [XLEN-1:0] pcp4_reg;
    logic [4:0]      rd_reg;
    logic [1:0]      off_reg;
    logic [2:0]      funct3_reg;

    assign size_m     = size_of(funct3M);
    assign off_m      = ALU_resultM[1:0];
    assign access_m   = validM & (mem_rdM | mem_wrM);
    assign misalign_m = access_m & is_misaligned(size_m, off_m);

`ifdef MEM_ACCESS_FAULT_EN
    assign fault_m = access_m & (|ALU_resultM[XLEN-1:ADDR_WIDTH+2]);
`else
    assign fault_m = 1'b0;
`endif

    // rst_n gates the write so a store caught by reset never commits.
    assign we_m = validM & mem_wrM & ~stallW & ~flushW & ~misalign_m & ~fault_m & rst_n;
    assign reg_wr_next = reg_wrM & ~(mem_rdM & misalign_m) & ~fault_m;

    dmem_bank #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_dmem (
        .clk  (clk),
        .csb  (stallW),
        .web  (~we_m),
        .wmask(wmask_gen(size_m, off_m)),
        .addr (ALU_resultM[ADDR_WIDTH+1:2]),
        .din  (store_rep(size_m, wr_dataM)),
        .dout (dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg      <= 1'b0;
            reg_wr_reg     <= 1'b0;
            misalign_reg   <= 1'b0;
            fault_reg      <= 1'b0;
            load_reg       <= 1'b0;
            result_src_reg <= '0;
            alu_result_reg <= '0;
            pcp4_reg       <= '0;
            rd_reg         <= '0;
            off_reg        <= '0;
            funct3_reg     <= '0;
        end else begin
            if (flushW) begin
                valid_reg    <= 1'b0;
                reg_wr_reg   <= 1'b0;
                misalign_reg <= 1'b0;
                fault_reg    <= 1'b0;
                load_reg     <= 1'b0;
            end else if (!stallW) begin
                valid_reg    <= validM;
                reg_wr_reg   <= reg_wr_next;
                misalign_reg <= misalign_m;
                fault_reg    <= fault_m;
                load_reg     <= validM & mem_rdM;
            end
            if (!stallW) begin
                result_src_reg <= result_srcM;
                alu_result_reg <= ALU_resultM;
                pcp4_reg       <= PCp4M;
                rd_reg         <= rdM;
                off_reg        <= off_m;
                funct3_reg     <= funct3M;
            end
        end
    end

    assign validW      = valid_reg;
    assign reg_wrW     = reg_wr_reg;
    assign result_srcW = result_src_reg;
    assign ALU_resultW = alu_result_reg;
    assign PCp4W       = pcp4_reg;
    assign rdW         = rd_reg;
    assign misalignW   = misalign_reg;
    assign faultW      = fault_reg;
    assign rd_dataW    = (valid_reg & load_reg & ~misalign_reg & ~fault_reg)
                         ? load_align(dout, off_reg, funct3_reg) : '0;

endmodule
